// File: rtl/lcd_fmt_pkg.sv
// Shared types and character constants for the LCD trace-word formatter.
package lcd_fmt_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LINE = 2'd1,
    S_EMIT = 2'd2
  } state_t;

  localparam int CHARS_PER_LINE = 16;
  localparam logic [3:0] LAST_IDX = 4'(CHARS_PER_LINE - 1);

  localparam logic [7:0] CH_O        = 8'h4F;
  localparam logic [7:0] CH_P        = 8'h50;
  localparam logic [7:0] CH_A        = 8'h41;
  localparam logic [7:0] CH_D        = 8'h44;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_A_OFS = 8'h37;

endpackage

// File: rtl/lcd_hex_ascii.sv
// Combinational nibble to uppercase ASCII hex digit.
module lcd_hex_ascii
  import lcd_fmt_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  assign ascii = (nibble < 4'd10) ? (ASCII_0 + {4'd0, nibble})
                                  : (ASCII_A_OFS + {4'd0, nibble});

endmodule

// File: rtl/lcd_word_formatter.sv
// Formats an 18-bit trace word into a line-select command plus 16 LCD characters.
// Build option LCD_FMT_LINE_ALT_EN: alternate between lines 0 and 1 per completed word.
module lcd_word_formatter
  import lcd_fmt_pkg::*;
#(
  parameter logic [7:0] PAD_CHAR = 8'h20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [17:0] word_in,
  input  logic        word_valid,
  output logic        word_ready,
  output logic [7:0]  out_data,
  output logic        out_cmd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  state_t      state;
  logic [17:0] wreg;
  logic [3:0]  idx;
  logic [3:0]  char_idx;
  logic [3:0]  nibble;
  logic [7:0]  hex_char;
  logic [7:0]  char_nxt;
  logic        line;
  logic        last;

  assign word_ready = (state == S_IDLE) && !rst;
  assign busy       = (state != S_IDLE);
  assign last       = (idx == LAST_IDX);

  // Outputs are registered, so the character is built for the position presented next.
  assign char_idx = (state == S_LINE) ? 4'd0 : idx + 4'd1;

  always_comb begin
    nibble = 4'd0;
    case (char_idx)
      4'd3:    nibble = {2'b00, wreg[17:16]};
      4'd4:    nibble = wreg[15:12];
      4'd9:    nibble = wreg[11:8];
      4'd10:   nibble = wreg[7:4];
      4'd11:   nibble = wreg[3:0];
      default: nibble = 4'd0;
    endcase
  end

  lcd_hex_ascii u_hex (
    .nibble (nibble),
    .ascii  (hex_char)
  );

  always_comb begin
    char_nxt = PAD_CHAR;
    case (char_idx)
      4'd0:                          char_nxt = CH_O;
      4'd1:                          char_nxt = CH_P;
      4'd3, 4'd4, 4'd9, 4'd10, 4'd11: char_nxt = hex_char;
      4'd6:                          char_nxt = CH_A;
      4'd7:                          char_nxt = CH_D;
      default:                       char_nxt = PAD_CHAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      out_cmd   <= 1'b0;
      out_data  <= 8'h00;
      idx       <= 4'd0;
      wreg      <= 18'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (word_valid && word_ready) begin
            wreg      <= word_in;
            idx       <= 4'd0;
            state     <= S_LINE;
            out_valid <= 1'b1;
            out_cmd   <= 1'b1;
            out_data  <= {7'd0, line};
          end
        end
        S_LINE: begin
          if (out_ready) begin
            state    <= S_EMIT;
            out_cmd  <= 1'b0;
            out_data <= char_nxt;
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            if (last) begin
              state     <= S_IDLE;
              out_valid <= 1'b0;
            end else begin
              idx      <= idx + 4'd1;
              out_data <= char_nxt;
            end
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef LCD_FMT_LINE_ALT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      line <= 1'b0;
    else if (state == S_EMIT && out_ready && last)
      line <= ~line;
  end
`else
  assign line = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_word_formatter.sv
// Directed self-checking bench for lcd_word_formatter.
module tb_lcd_word_formatter;

  logic        clk;
  logic        rst;
  logic [17:0] word_in;
  logic        word_valid;
  logic        word_ready;
  logic [7:0]  out_data;
  logic        out_cmd;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_cnt = 0;
  int acc[$];
  logic [7:0] exp_line = 8'd0;

  lcd_word_formatter dut (
    .clk        (clk),
    .rst        (rst),
    .word_in    (word_in),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .out_data   (out_data),
    .out_cmd    (out_cmd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (word_valid && word_ready) acc.push_back(cyc_cnt);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [17:0] w, input bit hold, input logic [17:0] nxt);
    int cyc = 0;
    word_in    = w;
    word_valid = 1'b1;
    while (!word_ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (!word_ready) check("accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    if (hold) word_in = nxt;
    else word_valid = 1'b0;
  endtask

  task automatic recv_line(input logic [7:0] line_no, input logic [127:0] chars, input bit stall);
    int n = 0;
    int cyc = 0;
    bit ready;
    bit have = 0;
    logic [7:0] hd = 8'h00;
    logic hc = 1'b0;
    while (n < 17 && cyc < 300) begin
      ready = stall ? ((cyc % 3) == 2) : 1'b1;
      out_ready = ready;
      if (out_valid) begin
        if (have) begin
          check("hold_data", {24'd0, out_data}, {24'd0, hd});
          check("hold_cmd", {31'd0, out_cmd}, {31'd0, hc});
        end
        if (stall) check("stall_word_ready", {31'd0, word_ready}, 32'd0);
        if (ready) begin
          if (n == 0) begin
            check("cmd_flag", {31'd0, out_cmd}, 32'd1);
            check("cmd_line", {24'd0, out_data}, {24'd0, line_no});
          end else begin
            check("chr_flag", {31'd0, out_cmd}, 32'd0);
            check($sformatf("chr%0d", n - 1), {24'd0, out_data}, {24'd0, chars[8*(16-n) +: 8]});
          end
          n++;
          have = 0;
        end else begin
          have = 1;
          hd = out_data;
          hc = out_cmd;
        end
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    if (n < 17) check("recv_timeout", n, 32'd17);
    check("done_word_ready", {31'd0, word_ready}, 32'd1);
    check("done_busy", {31'd0, busy}, 32'd0);
    check("done_valid", {31'd0, out_valid}, 32'd0);
`ifdef LCD_FMT_LINE_ALT_EN
    exp_line = exp_line ^ 8'd1;
`endif
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; word_in = 18'd0; word_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_cmd", {31'd0, out_cmd}, 32'd0);
    check("rst_data", {24'd0, out_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_word_ready", {31'd0, word_ready}, 32'd0);
    rst = 1'b0;
    #1 check("post_rst_word_ready", {31'd0, word_ready}, 32'd1);
    @(negedge clk);

    send(18'h0A00D, 0, 18'd0);
    recv_line(exp_line, "OP 0A AD 00D    ", 0);

    send(18'h3FFFF, 0, 18'd0);
    recv_line(exp_line, "OP 3F AD FFF    ", 0);
    send(18'h00000, 0, 18'd0);
    recv_line(exp_line, "OP 00 AD 000    ", 0);
    check("gap_b2b", acc[$] - acc[$-1], 32'd18);

    send(18'h12345, 0, 18'd0);
    recv_line(exp_line, "OP 12 AD 345    ", 1);

    // word_valid stays high with new data while the first word is emitted
    send(18'h2ABCD, 1, 18'h15555);
    recv_line(exp_line, "OP 2A AD BCD    ", 0);
    @(negedge clk);
    word_valid = 1'b0;
    recv_line(exp_line, "OP 15 AD 555    ", 0);
    check("gap_held_valid", acc[$] - acc[$-1], 32'd18);

    send(18'h0A00D, 0, 18'd0);
    out_ready = 1'b1;
    repeat (8) @(negedge clk);
    check("pre_rst_chr", {24'd0, out_data}, 32'h44);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_word_ready", {31'd0, word_ready}, 32'd0);
    exp_line = 8'd0;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    #1 check("rel_word_ready", {31'd0, word_ready}, 32'd1);
    send(18'h3FFFF, 0, 18'd0);
    recv_line(exp_line, "OP 3F AD FFF    ", 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
